// File: rtl/motion_pkg.sv
// Shared motion-stage definitions: velocity/acceleration width, velocity
// clamp and abort-deceleration defaults (shared with the acc_step_gen-level
// configuration), and the calc FSM state encoding of speed_integrator.
package motion_pkg;
    localparam int VEL_W = 32;

    localparam logic [VEL_W-1:0] MAX_SPEED_DEF = 32'h7FFF_FFFF;
    localparam logic [VEL_W-1:0] ABORT_DEC_DEF = 32'h0000_1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_CLAMP = 2'd2,
        S_DONE  = 2'd3
    } calc_state_e;
endpackage

// File: rtl/step_pulse_stretcher.sv
// Turns every transition of one position-accumulator bit into a fixed-width
// step pulse and latches the direction at the rising edge of that pulse.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bit_i       - monitored accumulator bit
//   dir_i       - direction to capture when a pulse starts
//   step_o      - step pulse, STEP_PULSE_CYCLES clocks wide
//   dir_o       - direction held for the duration of the pulse
//   overrun_o   - sticky: a transition arrived while a pulse was still active
module step_pulse_stretcher #(
    parameter int STEP_PULSE_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_i,
    input  logic dir_i,
    output logic step_o,
    output logic dir_o,
    output logic overrun_o
);
    localparam int CNT_W = $clog2(STEP_PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(STEP_PULSE_CYCLES);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             ovr_q;
    logic             trans;

    assign trans = bit_i ^ prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            prev_q <= bit_i;
            if (trans) begin
                // A transition always (re)starts the pulse; hitting one that
                // is still running means steps are coming too fast.
                cnt_q <= PULSE_CNT;
                dir_q <= dir_i;
                if (cnt_q != '0) ovr_q <= 1'b1;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign step_o    = (cnt_q != '0);
    assign dir_o     = dir_q;
    assign overrun_o = ovr_q;
endmodule

// File: rtl/speed_integrator.sv
// Per-axis speed integrator. A start_calc request computes the next segment
// velocity (planned + acceleration, clamped to +/-MAX_SPEED) over three
// cycles and pulses acc_calc_done. load_speeds commits that velocity; the
// committed speed is integrated into a wrapping position accumulator every
// clock, and transitions of position[STEP_BIT] produce step/dir pulses.
// global_abort switches the acceleration source to a fixed deceleration
// towards zero until both planned and committed velocity reach zero.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   acc_in, acc_write   - acceleration register write
//   start_calc          - start next-velocity computation
//   load_speeds         - commit computed velocity
//   global_abort        - enter abort deceleration, cancels in-flight calc
//   acc_calc_done       - one-cycle pulse when a computation finishes
//   abort_pending       - aborting and velocity not yet zero
//   step, dir           - step pulse and direction (1 = negative)
//   speed, position     - committed velocity and accumulator (debug)
//   error_calc_overlap  - sticky: start_calc while a calc was busy
//   error_step_overrun  - sticky: step transition during an active pulse
module speed_integrator
    import motion_pkg::*;
#(
    parameter int               POS_W             = 64,
    parameter int               STEP_BIT          = 32,
    parameter int               STEP_PULSE_CYCLES = 10,
    parameter logic [VEL_W-1:0] MAX_SPEED         = MAX_SPEED_DEF,
    parameter logic [VEL_W-1:0] ABORT_DEC         = ABORT_DEC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VEL_W-1:0] acc_in,
    input  logic             acc_write,
    input  logic             start_calc,
    input  logic             load_speeds,
    input  logic             global_abort,
    output logic             acc_calc_done,
    output logic             abort_pending,
    output logic             step,
    output logic             dir,
    output logic [VEL_W-1:0] speed,
    output logic [POS_W-1:0] position,
    output logic             error_calc_overlap,
    output logic             error_step_overrun
);
    localparam logic signed [VEL_W-1:0] ABORT_S = signed'(ABORT_DEC);
    localparam logic signed [VEL_W:0]   MAX_S   = {1'b0, MAX_SPEED};
    localparam logic signed [VEL_W:0]   MIN_S   = -MAX_S;

    calc_state_e              state_q;
    logic signed [VEL_W-1:0]  acc_q, planned_q, planned_next_q, speed_q;
    logic signed [VEL_W:0]    sum_q;
    logic                     ab_dn_q, ab_up_q;
    logic                     abort_q, pend_q, done_q, err_ovl_q;
    logic        [POS_W-1:0]  pos_q;

    logic signed [VEL_W-1:0]  eff_acc_d, clamp_d;
    logic signed [VEL_W:0]    sum_d;

    // In abort mode the acceleration is replaced by a fixed step towards 0.
    always_comb begin
        eff_acc_d = acc_q;
        if (abort_q) begin
            if (planned_q > 0)      eff_acc_d = -ABORT_S;
            else if (planned_q < 0) eff_acc_d = ABORT_S;
            else                    eff_acc_d = '0;
        end
    end

    assign sum_d = {planned_q[VEL_W-1], planned_q} + {eff_acc_d[VEL_W-1], eff_acc_d};

    // Abort deceleration must land exactly on zero rather than overshoot.
    always_comb begin
        clamp_d = sum_q[VEL_W-1:0];
        if (ab_dn_q && sum_q <= 0)      clamp_d = '0;
        else if (ab_up_q && sum_q >= 0) clamp_d = '0;
        else if (sum_q > MAX_S)         clamp_d = MAX_S[VEL_W-1:0];
        else if (sum_q < MIN_S)         clamp_d = MIN_S[VEL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            planned_q      <= '0;
            planned_next_q <= '0;
            speed_q        <= '0;
            sum_q          <= '0;
            ab_dn_q        <= 1'b0;
            ab_up_q        <= 1'b0;
            abort_q        <= 1'b0;
            pend_q         <= 1'b0;
            done_q         <= 1'b0;
            err_ovl_q      <= 1'b0;
            pos_q          <= '0;
        end else begin
            done_q <= 1'b0;
            if (acc_write) acc_q <= acc_in;
            if (start_calc && state_q != S_IDLE) err_ovl_q <= 1'b1;

            if (global_abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (start_calc) state_q <= S_ADD;
                    S_ADD: begin
                        sum_q   <= sum_d;
                        ab_dn_q <= abort_q && (planned_q > 0);
                        ab_up_q <= abort_q && (planned_q < 0);
                        state_q <= S_CLAMP;
                    end
                    S_CLAMP: begin
                        planned_next_q <= clamp_d;
                        done_q         <= 1'b1;
                        state_q        <= S_DONE;
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end

            if (load_speeds) begin
                speed_q   <= planned_next_q;
                planned_q <= planned_next_q;
            end

            if (global_abort)                        abort_q <= 1'b1;
            else if (speed_q == 0 && planned_q == 0) abort_q <= 1'b0;
            pend_q <= abort_q && (speed_q != 0 || planned_q != 0);

            pos_q <= pos_q + {{(POS_W-VEL_W){speed_q[VEL_W-1]}}, speed_q};
        end
    end

    step_pulse_stretcher #(
        .STEP_PULSE_CYCLES(STEP_PULSE_CYCLES)
    ) u_step (
        .clk      (clk),
        .reset    (reset),
        .bit_i    (pos_q[STEP_BIT]),
        .dir_i    (speed_q[VEL_W-1]),
        .step_o   (step),
        .dir_o    (dir),
        .overrun_o(error_step_overrun)
    );

    assign acc_calc_done      = done_q;
    assign abort_pending      = pend_q;
    assign speed              = speed_q;
    assign position           = pos_q;
    assign error_calc_overlap = err_ovl_q;
endmodule
